board_forwarder: RTL
====================

# board_forwarder

Downstream consumer of the 4-way round-robin board arbiter. Each cycle it presents the arbiter's request mask and pulses the arbiter's enable to obtain a one-hot grant. It then locks onto the granted board and forwards that board's multi-flit packet through a single registered output stage until the last flit. The grant is held for the whole packet and re-arbitration happens only on packet boundaries.

## Interface
Parameters:
- DATA_W, 64, flit payload width
- MAX_FLITS, 255, longest legal packet in flits; counter width is clog2(MAX_FLITS+1)

Ports:
- clk  in  1  sole clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  4  per-board flit valid
- in_data  in  4*DATA_W  per-board flit payload, board i at [i*DATA_W +: DATA_W]
- in_last  in  4  per-board end-of-packet marker
- in_ready  out  4  per-board accept; at most one bit high
- req_mask  out  4  request mask to the arbiter, equal to in_valid
- arb_enable  out  1  one-cycle pulse that advances the arbiter
- grant_mask  in  4  arbiter's registered one-hot grant; 0 means no grant
- out_valid  out  1  output flit valid
- out_data  out  DATA_W  output payload
- out_last  out  1  output end-of-packet
- out_sel  out  2  source board of the current output flit
- out_ready  in  1  downstream accept
- pkt_count  out  16  packets completed, wraps at 2^16
- len_err  out  1  sticky; set when a packet exceeds MAX_FLITS

## Operation
FSM states: IDLE, ARB, GRANT, XFER.
- IDLE: if req_mask != 0, go to ARB. Otherwise stay.
- ARB: arb_enable=1 for exactly this cycle, then go to GRANT.
- GRANT: sample grant_mask.
  - One-hot: latch sel = index of the set bit, go to XFER.
  - Zero: the arbiter masks the previous winner, so a lone repeat requester yields 0. Go to ARB if req_mask != 0, else IDLE.
  - Any other value: treat as zero.
- XFER: in_ready[sel] = (!out_valid | out_ready); the other ready bits are 0.
  - A transfer is in_valid[sel] & in_ready[sel]. It loads the output register with in_data[sel], in_last[sel] and sel.
  - When the transferred flit has in_last=1: increment pkt_count, clear the flit counter, go to IDLE.
- grant_mask is ignored in every state except GRANT. arb_enable is 0 outside ARB.
- Output register: out_valid is set on a transfer. It clears on out_ready when no new transfer happens in the same cycle. A transfer and a drain in the same cycle keep out_valid=1 with the new data.
- Flit counter: increments on each transfer and saturates at MAX_FLITS.
  - A transfer when the count is already MAX_FLITS and in_last=0 sets len_err.
  - The flit is still forwarded. len_err clears only on rst.
- in_ready is 0 in IDLE, ARB and GRANT.

## Timing
- Reset values: state=IDLE, in_ready=0, arb_enable=0, out_valid=0, out_last=0, out_data=0, out_sel=0, pkt_count=0, len_err=0, flit counter=0.
- req_mask is combinational from in_valid, so it is also 0 in reset only if in_valid is 0.
- Arbitration latency: request seen in IDLE at cycle t, arb_enable at t+1, grant sampled at t+2, first in_ready at t+3.
- A flit accepted at cycle t appears on out_valid/out_data at t+1.
- Zero-grant retry costs 2 cycles per attempt (ARB, GRANT).
- Source drops in_valid mid-packet: stay in XFER and wait; there is no timeout.
- rst mid-packet: abort immediately. The partially sent packet is not completed and out_valid drops next cycle.
- Back-pressure: out_ready=0 with out_valid=1 holds in_ready low and out_data stable.
- pkt_count 0xFFFF plus one completion gives 0x0000.

## Structure
- Shared package board_pkg: NUM_BOARDS=4, BOARD_IDX_W=2, the FSM state enum, and the onehot_to_idx function with its valid flag.
- The arbiter is not instantiated inside this block. The integrating top connects req_mask/arb_enable/grant_mask to it.
- One natural sub-module: fwd_out_reg, the single-entry valid/ready output register carrying data, last and sel.

## Test plan
- Single request: in_valid=4'b0100 with a 3-flit packet. Expect arb_enable pulse, grant 4'b0100 two cycles later, 3 output flits with out_sel=2, out_last on the third, pkt_count=1.
- Round robin: all 4 boards hold 1-flit packets. Expect out_sel order 0,1,2,3, each preceded by one arb_enable pulse.
- Lone repeat requester: board 1 sends two consecutive packets. On the second packet grant_mask=0 once, then arb_enable re-pulses, then the grant is 4'b0010 and the packet is forwarded.
- Back-pressure: out_ready=0 for 5 cycles mid-packet. Expect in_ready[sel]=0, out_data unchanged, no flit lost or duplicated.
- Length error with MAX_FLITS=4: send a 6-flit packet. Expect all 6 flits forwarded and len_err=1 from the 5th transfer onward.
- Reset mid-packet: assert rst after flit 2 of 5. Expect out_valid=0, state IDLE, pkt_count=0 on the next cycle.

Source files
------------

// File: rtl/board_pkg.sv
// Shared definitions for the board forwarder: board count, FSM states and
// the one-hot grant decoder.
package board_pkg;
  localparam int NUM_BOARDS  = 4;
  localparam int BOARD_IDX_W = 2;

  typedef enum logic [1:0] {IDLE, ARB, GRANT, XFER} fwd_state_e;

  typedef struct packed {
    logic                   vld;
    logic [BOARD_IDX_W-1:0] idx;
  } onehot_idx_t;

  // vld is set only for exactly one bit high; idx is meaningful only then.
  function automatic onehot_idx_t onehot_to_idx(input logic [NUM_BOARDS-1:0] oh);
    onehot_idx_t r;
    r = '0;
    for (int i = 0; i < NUM_BOARDS; i++)
      if (oh[i]) r.idx = BOARD_IDX_W'(i);
    r.vld = (oh != '0) && ((oh & (oh - NUM_BOARDS'(1))) == '0);
    return r;
  endfunction
endpackage

// File: rtl/fwd_out_reg.sv
// Single-entry valid/ready output register carrying payload, last and source.
module fwd_out_reg
  import board_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  input  logic [BOARD_IDX_W-1:0] in_sel,
  input  logic                   out_ready,
  output logic                   can_load,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [BOARD_IDX_W-1:0] out_sel
);
  // A new flit may enter when the slot is empty or drains this cycle.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
      out_sel   <= in_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/board_forwarder.sv
// Arbitrates among four boards through an external round-robin arbiter and
// forwards the granted board's whole packet before re-arbitrating.
module board_forwarder
  import board_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_FLITS = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BOARDS-1:0]        in_valid,
  input  logic [NUM_BOARDS*DATA_W-1:0] in_data,
  input  logic [NUM_BOARDS-1:0]        in_last,
  output logic [NUM_BOARDS-1:0]        in_ready,
  output logic [NUM_BOARDS-1:0]        req_mask,
  output logic                         arb_enable,
  input  logic [NUM_BOARDS-1:0]        grant_mask,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_last,
  output logic [BOARD_IDX_W-1:0]       out_sel,
  input  logic                         out_ready,
  output logic [15:0]                  pkt_count,
  output logic                         len_err
);
  localparam int              CNT_W   = $clog2(MAX_FLITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FLITS);

  fwd_state_e                          state, state_d;
  logic [BOARD_IDX_W-1:0]              sel, sel_d;
  logic [CNT_W-1:0]                    flit_cnt;
  logic [NUM_BOARDS-1:0][DATA_W-1:0]   in_data_a;
  logic [DATA_W-1:0]                   sel_data;
  logic                                sel_last;
  logic                                can_load;
  logic                                xfer;
  onehot_idx_t                         gnt;

  assign in_data_a = in_data;
  assign req_mask  = in_valid;
  assign gnt       = onehot_to_idx(grant_mask);
  assign sel_data  = in_data_a[sel];
  assign sel_last  = in_last[sel];
  assign xfer      = (state == XFER) && in_valid[sel] && can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
    end
  end

  always_comb begin
    state_d    = state;
    sel_d      = sel;
    arb_enable = 1'b0;
    in_ready   = '0;
    case (state)
      IDLE:  if (req_mask != '0) state_d = ARB;
      ARB: begin
        arb_enable = 1'b1;
        state_d    = GRANT;
      end
      // A zero or malformed grant means the arbiter masked a lone repeat
      // requester; retry while anyone is still asking.
      GRANT: begin
        if (gnt.vld) begin
          sel_d   = gnt.idx;
          state_d = XFER;
        end else if (req_mask != '0) begin
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        in_ready[sel] = can_load;
        if (xfer && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flit counter saturates; overlong packets are still forwarded but flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_cnt  <= '0;
      pkt_count <= '0;
      len_err   <= 1'b0;
    end else if (xfer) begin
      if (flit_cnt == CNT_MAX && !sel_last) len_err <= 1'b1;
      if (sel_last) begin
        flit_cnt  <= '0;
        pkt_count <= pkt_count + 16'd1;
      end else if (flit_cnt != CNT_MAX) begin
        flit_cnt <= flit_cnt + CNT_W'(1);
      end
    end
  end

  fwd_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .in_data   (sel_data),
    .in_last   (sel_last),
    .in_sel    (sel),
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );
endmodule
